// File: rtl/tone_sample_gen_pkg.sv
// tone_sample_gen_pkg: shared audio constants and the tone player state type.
package tone_sample_gen_pkg;
  localparam int DATA_W = 24;
  localparam logic [23:0] AMPLITUDE = 24'h200000;
  typedef enum logic {IDLE, PLAY} state_t;
endpackage

// File: rtl/tone_sample_gen_square_osc.sv
// square_osc: half-period phase counter; polarity 0 is the positive half, 1 the negative half.
module square_osc (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] half_period,
  output logic        polarity
);
  logic [15:0] phase_cnt;
  logic        wrap;
  assign wrap = phase_cnt == half_period - 16'd1;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_cnt <= '0;
      polarity  <= 1'b0;
    end else if (load) begin
      phase_cnt <= '0;
      polarity  <= 1'b0;
    end else if (step) begin
      phase_cnt <= wrap ? '0 : phase_cnt + 16'd1;
      polarity  <= polarity ^ wrap;
    end
  end
endmodule

// File: rtl/tone_sample_gen.sv
// tone_sample_gen: square-wave tone player feeding signed samples to the CODEC write handshake.
module tone_sample_gen #(
  parameter int               DATA_W    = tone_sample_gen_pkg::DATA_W,
  parameter logic [DATA_W-1:0] AMPLITUDE = tone_sample_gen_pkg::AMPLITUDE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [15:0]       note_half_period,
  input  logic [15:0]       note_len,
  input  logic [2:0]        volume,
  input  logic              mute,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy
);
  import tone_sample_gen_pkg::*;
  state_t            state, state_nx;
  logic [15:0]       half_period, remaining;
  logic              accept, strobe, step, last, polarity;
  logic [DATA_W-1:0] mag, sample;
  assign note_ready = state == IDLE;
  assign busy       = state == PLAY;
  assign accept     = note_valid & note_ready;
  // Never strobe two cycles in a row, so the CODEC always sees a gap.
  assign strobe     = write_ready & ~write;
  assign step       = strobe & busy & |half_period;
  assign last       = strobe & busy & (remaining == 16'd1);
  assign mag        = AMPLITUDE >> volume;
  assign writedata_right = writedata_left;
  always_comb begin
    state_nx = state;
    sample   = (busy & ~mute & |half_period) ? (polarity ? -mag : mag) : '0;
    if (accept && |note_len) state_nx = PLAY;
    if (last) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      half_period    <= '0;
      remaining      <= '0;
      write          <= 1'b0;
      writedata_left <= '0;
    end else begin
      state <= state_nx;
      write <= strobe;
      if (strobe) writedata_left <= sample;
      if (accept) begin
        half_period <= note_half_period;
        remaining   <= note_len;
      end else if (strobe && busy) begin
        remaining <= remaining - 16'd1;
      end
    end
  end
  square_osc u_osc (
    .clk        (clk),
    .resetn     (resetn),
    .load       (accept),
    .step       (step),
    .half_period(half_period),
    .polarity   (polarity)
  );
endmodule
